// File: rtl/generic_bus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : generic_bus_ram_responder
//  Purpose  : Word-organised RAM on the responder side of the generic bus.
//             Each request is captured in IDLE, held for LATENCY wait
//             cycles, then completed in a single DONE cycle with busy low.
//             Writes honour byte lanes; a combined read/write returns the
//             pre-write word.
//  Revision : 1.0 - initial release
// ============================================================================
module generic_bus_ram_responder #(
   parameter int LATENCY       = 2,     // wait-state cycles, 1..15
   parameter int DEPTH_WORDS   = 1024,  // 32-bit words, power of two
   parameter int RAM_ADDR_SIZE = 16     // byte address width
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [RAM_ADDR_SIZE-1:0] addr,
   input  logic                     ren,
   input  logic                     wen,
   input  logic [31:0]              wdata,
   input  logic [3:0]               byte_en,
   output logic [31:0]              rdata,
   output logic                     busy
);

   localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [3:0]           r_count;
   logic [3:0]           w_count_next;
   logic                 w_capture;
   logic                 w_commit;
   logic                 w_busy;

   // Request captured at acceptance; the bus inputs are free to change after.
   logic [c_idx_w-1:0]   r_idx;
   logic                 r_ren;
   logic                 r_wen;
   logic [31:0]          r_wdata;
   logic [3:0]           r_byte_en;

   logic [31:0]          r_rdata;
   logic [31:0]          r_mem [DEPTH_WORDS];

   // Byte-offset bits and bits above the index are deliberately ignored;
   // the upper bits give modulo-DEPTH_WORDS wrap-around.
   logic                 w_addr_unused;
   generate
      if (RAM_ADDR_SIZE > c_idx_w + 2) begin : g_addr_upper
         assign w_addr_unused = ^{addr[1:0], addr[RAM_ADDR_SIZE-1:c_idx_w+2]};
      end else begin : g_addr_exact
         assign w_addr_unused = ^addr[1:0];
      end
   endgenerate

   // State and latency counter register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= S_IDLE;
         r_count <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
      end
   end

   // Next-state, counter and busy decode.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_capture    = 1'b0;
      w_commit     = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = ren | wen;
            if (ren | wen) begin
               w_capture    = 1'b1;
               w_count_next = c_lat_load;
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            w_busy = 1'b1;
            if (r_count == 4'd0) begin
               w_commit     = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_count_next = r_count - 4'd1;
            end
         end
         S_DONE: begin
            // Completion cycle: a request still asserted here is picked up
            // in the following IDLE cycle, never in DONE itself.
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign busy = w_busy;

   // Capture the request fields at acceptance.
   always_ff @(posedge CLK) begin
      if (w_capture) begin
         r_idx     <= addr[c_idx_w+1:2];
         r_ren     <= ren;
         r_wen     <= wen;
         r_wdata   <= wdata;
         r_byte_en <= byte_en;
      end
   end

   // Read data loads the pre-write word at completion of a read; it holds
   // otherwise, including across write-only transactions.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_rdata <= 32'd0;
      end else if (w_commit && r_ren) begin
         r_rdata <= r_mem[r_idx];
      end
   end

   assign rdata = r_rdata;

   // Byte-lane write at completion; a reset during WAIT suppresses it.
   // Memory contents themselves are never cleared.
   always_ff @(posedge CLK) begin
      if (nRST && w_commit && r_wen) begin
         for (int i = 0; i < 4; i++) begin
            if (r_byte_en[i]) begin
               r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire
